// File: rtl/mips_mmio_bridge.sv
// Memory-port bridge for the multicycle core: RAM pass-through plus a
// peripheral page with LEDs, synchronized switches, a cycle counter and a timer.
module mips_mmio_bridge #(
    parameter int          N         = 32,
    parameter int          RAM_AW    = 10,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_wr_ena,
    input  logic [N-1:0]      core_addr,
    input  logic [N-1:0]      core_wr_data,
    output logic [N-1:0]      core_rd_data,
    output logic              ram_wr_ena,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [N-1:0]      ram_wr_data,
    input  logic [N-1:0]      ram_rd_data,
    input  logic [15:0]       sw_in,
    output logic [15:0]       led_out,
    output logic              timer_irq
);

    localparam logic [N-1:0] ONE = N'(1);

    logic          mmio_sel;
    logic          wr;
    logic [13:0]   word;
    logic [N-1:0]  mmio_rd;
    logic          unused;

    logic [15:0]   led;
    logic [15:0]   sw_s1;
    logic [15:0]   sw_s2;
    logic [N-1:0]  cycle;
    logic          en;
    logic          auto_rl;
    logic [N-1:0]  tload;
    logic [N-1:0]  tcount;
    logic          exp_flag;

    logic wr_led, wr_tctrl, wr_tload, wr_tstat;
    logic expire;

    assign mmio_sel    = (core_addr[31:16] == MMIO_BASE[31:16]);
    assign word        = core_addr[15:2];
    assign wr          = core_wr_ena & mmio_sel;
    assign unused      = ^core_addr[1:0];

    assign ram_addr    = core_addr[RAM_AW+1:2];
    assign ram_wr_data = core_wr_data;
    assign ram_wr_ena  = core_wr_ena & ~mmio_sel;

    assign core_rd_data = mmio_sel ? mmio_rd : ram_rd_data;

    assign wr_led   = wr && (word == 14'd0);
    assign wr_tctrl = wr && (word == 14'd3);
    assign wr_tload = wr && (word == 14'd4);
    assign wr_tstat = wr && (word == 14'd6);

    assign expire   = en && (tcount == '0);

    assign led_out   = led;
    assign timer_irq = exp_flag;

    always_comb begin
        mmio_rd = '0;
        case (word)
            14'd0:   mmio_rd = {{(N-16){1'b0}}, led};
            14'd1:   mmio_rd = {{(N-16){1'b0}}, sw_s2};
            14'd2:   mmio_rd = cycle;
            14'd3:   mmio_rd = {{(N-2){1'b0}}, auto_rl, en};
            14'd4:   mmio_rd = tload;
            14'd5:   mmio_rd = tcount;
            14'd6:   mmio_rd = {{(N-1){1'b0}}, exp_flag};
            default: mmio_rd = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led      <= '0;
            sw_s1    <= '0;
            sw_s2    <= '0;
            cycle    <= '0;
            en       <= 1'b0;
            auto_rl  <= 1'b0;
            tload    <= '0;
            tcount   <= '0;
            exp_flag <= 1'b0;
        end else begin
            cycle <= cycle + ONE;
            sw_s1 <= sw_in;
            sw_s2 <= sw_s1;
            if (wr_led) led <= core_wr_data[15:0];
            if (en) begin
                if (tcount != '0) tcount <= tcount - ONE;
                else if (auto_rl) tcount <= tload;
                else en <= 1'b0;
            end
            // Software writes land last so they beat the timer's own updates.
            if (wr_tctrl) begin
                en      <= core_wr_data[0];
                auto_rl <= core_wr_data[1];
            end
            if (wr_tload) begin
                tload  <= core_wr_data;
                tcount <= core_wr_data;
            end
            if (expire) exp_flag <= 1'b1;
            else if (wr_tstat && core_wr_data[0]) exp_flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_mmio_bridge.sv
// Directed bench for mips_mmio_bridge with a behavioural RAM model.
module tb_mips_mmio_bridge;

    localparam logic [31:0] A_LED   = 32'hFFFF_0000;
    localparam logic [31:0] A_SW    = 32'hFFFF_0004;
    localparam logic [31:0] A_CYC   = 32'hFFFF_0008;
    localparam logic [31:0] A_TCTRL = 32'hFFFF_000C;
    localparam logic [31:0] A_TLOAD = 32'hFFFF_0010;
    localparam logic [31:0] A_TCNT  = 32'hFFFF_0014;
    localparam logic [31:0] A_TSTAT = 32'hFFFF_0018;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        core_wr_ena = 1'b0;
    logic [31:0] core_addr = '0;
    logic [31:0] core_wr_data = '0;
    logic [31:0] core_rd_data;
    logic        ram_wr_ena;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wr_data;
    logic [31:0] ram_rd_data;
    logic [15:0] sw_in = '0;
    logic [15:0] led_out;
    logic        timer_irq;

    logic [31:0] mem [1024];
    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] d;

    always #5 clk = ~clk;

    assign ram_rd_data = mem[ram_addr];
    always @(posedge clk) if (ram_wr_ena) mem[ram_addr] <= ram_wr_data;

    mips_mmio_bridge dut (
        .clk(clk), .rst(rst),
        .core_wr_ena(core_wr_ena), .core_addr(core_addr),
        .core_wr_data(core_wr_data), .core_rd_data(core_rd_data),
        .ram_wr_ena(ram_wr_ena), .ram_addr(ram_addr),
        .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data),
        .sw_in(sw_in), .led_out(led_out), .timer_irq(timer_irq)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] v);
        core_addr = a;
        core_wr_data = v;
        core_wr_ena = 1'b1;
        tick();
        core_wr_ena = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        core_wr_ena = 1'b0;
        core_addr = a;
        #1;
        v = core_rd_data;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        #1;
        n_checks++; if (led_out !== 16'h0) begin n_fail++; $display("FAIL rst_led: got %h want 0000", led_out); end
        n_checks++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %b want 0", timer_irq); end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_ram_passthru();
        core_addr = 32'h0000_0010;
        core_wr_data = 32'hDEAD_BEEF;
        core_wr_ena = 1'b1;
        #1;
        n_checks++; if (ram_wr_ena !== 1'b1) begin n_fail++; $display("FAIL ram_we: got %b want 1", ram_wr_ena); end
        n_checks++; if (ram_addr !== 10'd4) begin n_fail++; $display("FAIL ram_addr: got %0d want 4", ram_addr); end
        tick();
        core_wr_ena = 1'b0;
        rd(32'h0000_0010, d);
        n_checks++; if (d !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_rd: got %h want deadbeef", d); end
        n_checks++; if (led_out !== 16'h0) begin n_fail++; $display("FAIL ram_led: got %h want 0000", led_out); end
    endtask

    task automatic test_led_decode();
        core_addr = A_LED;
        core_wr_data = 32'h1234_ABCD;
        core_wr_ena = 1'b1;
        #1;
        n_checks++; if (ram_wr_ena !== 1'b0) begin n_fail++; $display("FAIL led_ramwe: got %b want 0", ram_wr_ena); end
        tick();
        core_wr_ena = 1'b0;
        n_checks++; if (led_out !== 16'hABCD) begin n_fail++; $display("FAIL led_out: got %h want abcd", led_out); end
        rd(A_LED, d);
        n_checks++; if (d !== 32'h0000_ABCD) begin n_fail++; $display("FAIL led_rd: got %h want 0000abcd", d); end
        rd(32'hFFFF_0040, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL hole_rd: got %h want 0", d); end
        wr(32'hFFFF_0040, 32'h5555_5555);
        wr(A_SW, 32'h1111_1111);
        n_checks++; if (led_out !== 16'hABCD) begin n_fail++; $display("FAIL hole_wr: got %h want abcd", led_out); end
        wr(A_TCTRL, 32'hFFFF_FFFC);
        rd(A_TCTRL, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL tctrl_bits: got %h want 0", d); end
    endtask

    task automatic test_cycle();
        logic [31:0] c0;
        rd(A_CYC, c0);
        tick();
        rd(A_CYC, d);
        n_checks++; if (d !== c0 + 32'd1) begin n_fail++; $display("FAIL cyc_inc: got %h want %h", d, c0 + 32'd1); end
        wr(A_CYC, 32'h0);
        rd(A_CYC, d);
        n_checks++; if (d !== c0 + 32'd2) begin n_fail++; $display("FAIL cyc_ro: got %h want %h", d, c0 + 32'd2); end
    endtask

    task automatic test_sw_sync();
        sw_in = 16'h00F0;
        rd(A_SW, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL sw_e0: got %h want 0", d); end
        tick();
        rd(A_SW, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL sw_e1: got %h want 0", d); end
        tick();
        rd(A_SW, d);
        n_checks++; if (d !== 32'h0000_00F0) begin n_fail++; $display("FAIL sw_e2: got %h want f0", d); end
    endtask

    task automatic test_oneshot();
        logic [31:0] exp_cnt;
        wr(A_TLOAD, 32'd3);
        wr(A_TCTRL, 32'd1);
        for (int i = 0; i < 4; i++) begin
            exp_cnt = 32'd3 - 32'(i);
            rd(A_TCNT, d);
            n_checks++; if (d !== exp_cnt) begin n_fail++; $display("FAIL os_cnt%0d: got %0d want %0d", i, d, exp_cnt); end
            if (i == 3) begin
                n_checks++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL os_early: got %b want 0", timer_irq); end
            end
            tick();
        end
        n_checks++; if (timer_irq !== 1'b1) begin n_fail++; $display("FAIL os_irq: got %b want 1", timer_irq); end
        rd(A_TSTAT, d);
        n_checks++; if (d !== 32'd1) begin n_fail++; $display("FAIL os_exp: got %h want 1", d); end
        rd(A_TCTRL, d);
        n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL os_en: got %h want 0", d); end
        tick();
        rd(A_TCNT, d);
        n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL os_hold: got %h want 0", d); end
        wr(A_TSTAT, 32'd0);
        n_checks++; if (timer_irq !== 1'b1) begin n_fail++; $display("FAIL os_w0: got %b want 1", timer_irq); end
        wr(A_TSTAT, 32'd1);
        n_checks++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL os_clr: got %b want 0", timer_irq); end
    endtask

    task automatic test_auto_reload();
        wr(A_TLOAD, 32'd1);
        wr(A_TCTRL, 32'd3);
        tick();
        n_checks++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL ar_e1: got %b want 0", timer_irq); end
        tick();
        n_checks++; if (timer_irq !== 1'b1) begin n_fail++; $display("FAIL ar_e2: got %b want 1", timer_irq); end
        rd(A_TCNT, d);
        n_checks++; if (d !== 32'd1) begin n_fail++; $display("FAIL ar_reload: got %h want 1", d); end
        wr(A_TSTAT, 32'd1);
        n_checks++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL ar_clr: got %b want 0", timer_irq); end
        wr(A_TSTAT, 32'd1);
        n_checks++; if (timer_irq !== 1'b1) begin n_fail++; $display("FAIL ar_setwins: got %b want 1", timer_irq); end
        rd(A_TCTRL, d);
        n_checks++; if (d !== 32'd3) begin n_fail++; $display("FAIL ar_ctrl: got %h want 3", d); end
        wr(A_TCTRL, 32'd0);
    endtask

    task automatic test_reset_midcount();
        wr(A_TLOAD, 32'd5);
        rd(A_TCNT, d);
        n_checks++; if (d !== 32'd5) begin n_fail++; $display("FAIL rm_pre: got %h want 5", d); end
        n_checks++; if (timer_irq !== 1'b1) begin n_fail++; $display("FAIL rm_preirq: got %b want 1", timer_irq); end
        core_addr = A_LED;
        core_wr_data = 32'h0000_7777;
        core_wr_ena = 1'b1;
        rst = 1'b0;
        #1;
        n_checks++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL rm_irq: got %b want 0", timer_irq); end
        tick();
        n_checks++; if (led_out !== 16'h0) begin n_fail++; $display("FAIL rm_drop: got %h want 0", led_out); end
        rd(A_TCNT, d);
        n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL rm_tcnt: got %h want 0", d); end
        rd(A_TLOAD, d);
        n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL rm_tload: got %h want 0", d); end
        rd(A_TSTAT, d);
        n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL rm_tstat: got %h want 0", d); end
        rd(A_SW, d);
        n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL rm_sw: got %h want 0", d); end
        rd(A_CYC, d);
        n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL rm_cyc: got %h want 0", d); end
        tick();
        rst = 1'b1;
        rd(A_CYC, d);
        n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL rel_cyc0: got %h want 0", d); end
        tick();
        rd(A_CYC, d);
        n_checks++; if (d !== 32'd1) begin n_fail++; $display("FAIL rel_cyc1: got %h want 1", d); end
        tick();
        rd(A_CYC, d);
        n_checks++; if (d !== 32'd2) begin n_fail++; $display("FAIL rel_cyc2: got %h want 2", d); end
        rd(A_TCNT, d);
        n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL rel_tcnt: got %h want 0", d); end
        n_checks++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL rel_irq: got %b want 0", timer_irq); end
    endtask

    initial begin
        test_reset();
        test_ram_passthru();
        test_led_decode();
        test_cycle();
        test_sw_sync();
        test_oneshot();
        test_auto_reload();
        test_reset_midcount();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
